// File: rtl/sda_reg_bus_pkg.sv
// Shared definitions for the SDAccel simple register bus: sequencer states and bus defaults.
// Register blocks on the bus import this package for the address width and error pattern.
package sda_reg_bus_pkg;

    localparam int unsigned REG_ADDR_WIDTH_DEF = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 256;
    localparam logic [31:0] ERROR_RDATA_DEF    = 32'hDEADC0DE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } bus_state_e;

endpackage

// File: rtl/sda_reg_bus_timer.sv
// Bus timeout timer: down-counter loaded on clear, terminal count when it reaches zero.
// tc_o asserts on the TimeoutCycles-th enabled cycle after clear.
module sda_reg_bus_timer
    import sda_reg_bus_pkg::*;
#(
    parameter int unsigned TimeoutCycles = TIMEOUT_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int unsigned CntWidth = $clog2(TimeoutCycles);
    localparam logic [CntWidth-1:0] LoadValue = CntWidth'(TimeoutCycles - 1);

    logic [CntWidth-1:0] count_q;

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= LoadValue;
        end else if (enable_i && (count_q != '0)) begin
            count_q <= count_q - CntWidth'(1);
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/sda_reg_bus_ctrl.sv
// Master-side sequencer for the simple register bus: one host access at a time, one-cycle response.
// Define SDA_REG_BUS_TIMEOUT_EN to fail unacknowledged accesses after TimeoutCycles ISSUE cycles.
//
// state    | meaning
// ST_IDLE  | hostReady=1, waiting for hostReq
// ST_ISSUE | regReq held, waiting for regAck (or timeout)
// ST_DRAIN | one cycle after the response; swallows late acks
module sda_reg_bus_ctrl
    import sda_reg_bus_pkg::*;
#(
    parameter int unsigned RegAddrWidth  = REG_ADDR_WIDTH_DEF,
    parameter int unsigned TimeoutCycles = TIMEOUT_CYCLES_DEF,
    parameter logic [31:0] ErrorRData    = ERROR_RDATA_DEF
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic                    host_req_i,
    output logic                    host_ready_o,
    input  logic                    host_write_en_i,
    input  logic [RegAddrWidth-1:0] host_addr_i,
    input  logic [31:0]             host_wdata_i,
    output logic                    host_ack_o,
    output logic                    host_err_o,
    output logic [31:0]             host_rdata_o,
    output logic                    reg_req_o,
    output logic                    reg_write_en_o,
    output logic [RegAddrWidth-1:0] reg_addr_o,
    output logic [31:0]             reg_wdata_o,
    input  logic                    reg_ack_i,
    input  logic [31:0]             reg_rdata_i,
    output logic [7:0]              bus_err_count_o
);

    bus_state_e              state_q;
    logic                    host_ready_q;
    logic                    host_ack_q;
    logic [31:0]             host_rdata_q;
    logic                    reg_req_q;
    logic                    reg_write_en_q;
    logic [RegAddrWidth-1:0] reg_addr_q;
    logic [31:0]             reg_wdata_q;

`ifdef SDA_REG_BUS_TIMEOUT_EN
    logic       host_err_q;
    logic [7:0] err_count_q;
    logic       timer_tc;

    sda_reg_bus_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .clear_i (state_q == ST_IDLE && host_req_i),
        .enable_i(state_q == ST_ISSUE && !reg_ack_i),
        .tc_o    (timer_tc)
    );

    assign host_err_o      = host_err_q;
    assign bus_err_count_o = err_count_q;
`else
    logic unused_cfg;
    assign unused_cfg      = (^ErrorRData) ^ (TimeoutCycles >= 4);
    assign host_err_o      = 1'b0;
    assign bus_err_count_o = 8'd0;
`endif

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q        <= ST_IDLE;
            host_ready_q   <= 1'b1;
            host_ack_q     <= 1'b0;
            host_rdata_q   <= '0;
            reg_req_q      <= 1'b0;
            reg_write_en_q <= 1'b0;
            reg_addr_q     <= '0;
            reg_wdata_q    <= '0;
`ifdef SDA_REG_BUS_TIMEOUT_EN
            host_err_q     <= 1'b0;
            err_count_q    <= '0;
`endif
        end else begin
            host_ack_q <= 1'b0;
`ifdef SDA_REG_BUS_TIMEOUT_EN
            host_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (host_req_i) begin
                        reg_write_en_q <= host_write_en_i;
                        reg_addr_q     <= host_addr_i;
                        reg_wdata_q    <= host_wdata_i;
                        reg_req_q      <= 1'b1;
                        host_ready_q   <= 1'b0;
                        state_q        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // An ack arriving on the terminal-count cycle still completes cleanly.
                    if (reg_ack_i) begin
                        reg_req_q    <= 1'b0;
                        host_ack_q   <= 1'b1;
                        host_rdata_q <= reg_write_en_q ? 32'd0 : reg_rdata_i;
                        state_q      <= ST_DRAIN;
                    end
`ifdef SDA_REG_BUS_TIMEOUT_EN
                    else if (timer_tc) begin
                        reg_req_q    <= 1'b0;
                        host_ack_q   <= 1'b1;
                        host_err_q   <= 1'b1;
                        host_rdata_q <= ErrorRData;
                        if (err_count_q != 8'hFF) begin
                            err_count_q <= err_count_q + 8'd1;
                        end
                        state_q      <= ST_DRAIN;
                    end
`endif
                end
                ST_DRAIN: begin
                    host_ready_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    reg_req_q    <= 1'b0;
                    host_ready_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign host_ready_o   = host_ready_q;
    assign host_ack_o     = host_ack_q;
    assign host_rdata_o   = host_rdata_q;
    assign reg_req_o      = reg_req_q;
    assign reg_write_en_o = reg_write_en_q;
    assign reg_addr_o     = reg_addr_q;
    assign reg_wdata_o    = reg_wdata_q;

endmodule

// File: tb/tb_sda_reg_bus_ctrl.sv
// Bench for sda_reg_bus_ctrl: directed and random accesses against a latency-based response model.
// Timeout-specific scenarios are built when SDA_REG_BUS_TIMEOUT_EN is defined.
module tb_sda_reg_bus_ctrl;

    localparam int          TIMEOUT  = 16;
    localparam logic [31:0] ERR_DATA = 32'hDEADC0DE;
`ifdef SDA_REG_BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        srst;
    logic        host_req;
    logic        host_ready;
    logic        host_write_en;
    logic [7:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic        host_err;
    logic [31:0] host_rdata;
    logic        reg_req;
    logic        reg_write_en;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic [7:0]  bus_err_count;

    int checks   = 0;
    int errors   = 0;
    int exp_errs = 0;
    int n_rst_ack;
    int k_rand;

    always #5 clk = ~clk;

    sda_reg_bus_ctrl #(
        .RegAddrWidth (8),
        .TimeoutCycles(TIMEOUT),
        .ErrorRData   (ERR_DATA)
    ) dut (
        .clk_i          (clk),
        .srst_i         (srst),
        .host_req_i     (host_req),
        .host_ready_o   (host_ready),
        .host_write_en_i(host_write_en),
        .host_addr_i    (host_addr),
        .host_wdata_i   (host_wdata),
        .host_ack_o     (host_ack),
        .host_err_o     (host_err),
        .host_rdata_o   (host_rdata),
        .reg_req_o      (reg_req),
        .reg_write_en_o (reg_write_en),
        .reg_addr_o     (reg_addr),
        .reg_wdata_o    (reg_wdata),
        .reg_ack_i      (reg_ack),
        .reg_rdata_i    (reg_rdata),
        .bus_err_count_o(bus_err_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access, starting in an idle cycle (cycle 0). The block acks k cycles after regReq
    // rises (k<0: never). Optionally spams hostReq during the access and acks again during DRAIN.
    task automatic txn(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [31:0] blk_data, input int k, input bit spam, input bit late);
        int          exp_ack;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          window;
        int          n_ack    = 0;
        int          req_bad  = 0;
        int          hold_bad = 0;
        if (TO_EN && (k < 0 || k > TIMEOUT - 1)) begin
            exp_ack   = 1 + TIMEOUT;
            exp_err   = 1'b1;
            exp_rdata = ERR_DATA;
        end else begin
            exp_ack   = 2 + k;
            exp_err   = 1'b0;
            exp_rdata = wr ? 32'd0 : blk_data;
        end
        window = exp_ack + 3;
        chk("ready_idle", 32'(host_ready), 32'd1);
        host_req      = 1'b1;
        host_write_en = wr;
        host_addr     = addr;
        host_wdata    = wdata;
        for (int c = 1; c <= window; c++) begin
            @(posedge clk); #1;
            if (spam && c <= exp_ack) begin
                host_req      = 1'b1;
                host_write_en = 1'($urandom);
                host_addr     = 8'($urandom);
                host_wdata    = $urandom;
            end else begin
                host_req = 1'b0;
            end
            reg_ack   = (k >= 0 && c == 1 + k) || (late && c == exp_ack);
            reg_rdata = (k >= 0 && c == 1 + k) ? blk_data : $urandom;
            if (reg_req !== (c < exp_ack)) req_bad++;
            if (reg_write_en !== wr || reg_addr !== addr || reg_wdata !== wdata) hold_bad++;
            if (host_ack === 1'b1) n_ack++;
            if (c == exp_ack) begin
                chk("ack_at", 32'(host_ack), 32'd1);
                chk("ack_err", 32'(host_err), 32'(exp_err));
                chk("ack_rdata", host_rdata, exp_rdata);
                chk("ready_busy", 32'(host_ready), 32'd0);
            end
            if (c == exp_ack + 2) chk("ready_back", 32'(host_ready), 32'd1);
        end
        reg_ack = 1'b0;
        if (exp_err) exp_errs = (exp_errs < 255) ? exp_errs + 1 : 255;
        chk("req_shape", req_bad, 32'd0);
        chk("bus_hold", hold_bad, 32'd0);
        chk("ack_count", n_ack, 32'd1);
        chk("err_count", 32'(bus_err_count), exp_errs);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst          = 1'b1;
        host_req      = 1'b0;
        host_write_en = 1'b0;
        host_addr     = 8'h00;
        host_wdata    = 32'h0;
        reg_ack       = 1'b0;
        reg_rdata     = 32'h0;
        #1;
        chk("rst_ready", 32'(host_ready), 32'd1);
        chk("rst_ack", 32'(host_ack), 32'd0);
        chk("rst_err", 32'(host_err), 32'd0);
        chk("rst_rdata", host_rdata, 32'd0);
        chk("rst_req", 32'(reg_req), 32'd0);
        chk("rst_we", 32'(reg_write_en), 32'd0);
        chk("rst_addr", 32'(reg_addr), 32'd0);
        chk("rst_wdata", reg_wdata, 32'd0);
        chk("rst_errcnt", 32'(bus_err_count), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        srst = 1'b0;
        @(posedge clk); #1;

        txn(1'b0, 8'h00, 32'h0, 32'h0000000C, 2, 1'b0, 1'b0);
        txn(1'b1, 8'h00, 32'h1, 32'h12345678, 1, 1'b0, 1'b0);
        txn(1'b0, 8'h12, 32'h0, 32'hA5A5A5A5, 3, 1'b1, 1'b0);
        txn(1'b0, 8'h34, 32'h0, 32'h0BADF00D, 0, 1'b0, 1'b1);
`ifdef SDA_REG_BUS_TIMEOUT_EN
        txn(1'b0, 8'hF0, 32'h0, 32'h0, -1, 1'b0, 1'b0);
        txn(1'b0, 8'h3C, 32'h0, 32'hCAFEF00D, TIMEOUT - 1, 1'b0, 1'b1);
        txn(1'b1, 8'h3D, 32'h77, 32'h0, TIMEOUT - 2, 1'b0, 1'b0);
        txn(1'b1, 8'h3E, 32'h55, 32'h0, TIMEOUT, 1'b1, 1'b1);
`else
        txn(1'b0, 8'hF0, 32'h0, 32'h600DBEEF, 1000, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef SDA_REG_BUS_TIMEOUT_EN
            k_rand = ($urandom_range(7, 0) == 0) ? -1 : int'($urandom_range(20, 0));
`else
            k_rand = int'($urandom_range(8, 0));
`endif
            txn(1'($urandom), 8'($urandom), $urandom, $urandom, k_rand,
                ($urandom_range(3, 0) == 0), ($urandom_range(2, 0) == 0));
        end

        // Reset in the middle of ISSUE: regReq must drop before the next clock edge.
        host_req      = 1'b1;
        host_write_en = 1'b0;
        host_addr     = 8'h55;
        host_wdata    = 32'h0;
        @(posedge clk); #1;
        host_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pre_req", 32'(reg_req), 32'd1);
        #2 srst = 1'b1;
        #1;
        chk("rst_async_req", 32'(reg_req), 32'd0);
        chk("rst_async_ready", 32'(host_ready), 32'd1);
        exp_errs = 0;
        @(posedge clk); #1;
        srst = 1'b0;
        n_rst_ack = 0;
        for (int c = 0; c < 20; c++) begin
            reg_ack = (c == 2);
            @(posedge clk); #1;
            if (host_ack === 1'b1) n_rst_ack++;
        end
        reg_ack = 1'b0;
        chk("rst_no_ack", n_rst_ack, 32'd0);
        chk("rst_errcnt_clr", 32'(bus_err_count), 32'd0);
        txn(1'b0, 8'h56, 32'h0, 32'h13579BDF, 4, 1'b0, 1'b0);

`ifdef SDA_REG_BUS_TIMEOUT_EN
        while (exp_errs < 255) begin
            txn(1'b0, 8'hEE, 32'h0, 32'h0, -1, 1'b0, 1'b0);
        end
        txn(1'b0, 8'hEF, 32'h0, 32'h0, -1, 1'b0, 1'b0);
        txn(1'b0, 8'h01, 32'h0, 32'h24681357, 5, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
